// File: rtl/alu_operand_fwd_stage.sv
// ALU operand-select stage with internal forwarding resolution,
// a one-cycle output register and saturating forward counters.
module alu_operand_fwd_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic              alu_src,
  input  logic              exmem_wr,
  input  logic [ADDR_W-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr,
  input  logic [ADDR_W-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  output logic [1:0]        sel_a,
  output logic [1:0]        sel_b,
  output logic [CNT_W-1:0]  fwd_cnt_ex,
  output logic [CNT_W-1:0]  fwd_cnt_wb
);

  localparam logic [1:0] SRC_RF  = 2'd0;
  localparam logic [1:0] SRC_EX  = 2'd1;
  localparam logic [1:0] SRC_WB  = 2'd2;
  localparam logic [1:0] SRC_IMM = 2'd3;

  logic              ex_a, wb_a, ex_b, wb_b;
  logic [DATA_W-1:0] nxt_a, nxt_b;
  logic [1:0]        nxt_sel_a, nxt_sel_b;
  logic [1:0]        n_ex, n_wb;
  logic [CNT_W:0]    sum_ex, sum_wb;
  logic [CNT_W-1:0]  sat_ex, sat_wb;
  logic              capture;

  // Register 0 is hard-wired, so it never matches a forward.
  assign ex_a = exmem_wr && (exmem_rd == rs_addr) && (rs_addr != '0);
  assign wb_a = memwb_wr && (memwb_rd == rs_addr) && (rs_addr != '0);
  assign ex_b = exmem_wr && (exmem_rd == rt_addr) && (rt_addr != '0);
  assign wb_b = memwb_wr && (memwb_rd == rt_addr) && (rt_addr != '0);

  always_comb begin
    nxt_a     = rs_data;
    nxt_sel_a = SRC_RF;
    priority case (1'b1)
      ex_a: begin
        nxt_a     = exmem_data;
        nxt_sel_a = SRC_EX;
      end
      wb_a: begin
        nxt_a     = memwb_data;
        nxt_sel_a = SRC_WB;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt_b     = rt_data;
    nxt_sel_b = SRC_RF;
    priority case (1'b1)
      alu_src: begin
        nxt_b     = imm;
        nxt_sel_b = SRC_IMM;
      end
      ex_b: begin
        nxt_b     = exmem_data;
        nxt_sel_b = SRC_EX;
      end
      wb_b: begin
        nxt_b     = memwb_data;
        nxt_sel_b = SRC_WB;
      end
      default: ;
    endcase
  end

  always_comb begin
    n_ex = {1'b0, nxt_sel_a == SRC_EX}
         + {1'b0, nxt_sel_b == SRC_EX};
    n_wb = {1'b0, nxt_sel_a == SRC_WB}
         + {1'b0, nxt_sel_b == SRC_WB};
    sum_ex = {1'b0, fwd_cnt_ex}
           + {{(CNT_W-1){1'b0}}, n_ex};
    sum_wb = {1'b0, fwd_cnt_wb}
           + {{(CNT_W-1){1'b0}}, n_wb};
    // Carry out means the true sum passed the max.
    sat_ex = sum_ex[CNT_W] ? '1 : sum_ex[CNT_W-1:0];
    sat_wb = sum_wb[CNT_W] ? '1 : sum_wb[CNT_W-1:0];
  end

  assign capture = in_valid && !flush;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      op_a       <= '0;
      op_b       <= '0;
      out_valid  <= 1'b0;
      sel_a      <= SRC_RF;
      sel_b      <= SRC_RF;
      fwd_cnt_ex <= '0;
      fwd_cnt_wb <= '0;
    end else if (!stall) begin
      op_a      <= nxt_a;
      op_b      <= nxt_b;
      sel_a     <= nxt_sel_a;
      sel_b     <= nxt_sel_b;
      out_valid <= capture;
      if (capture) begin
        fwd_cnt_ex <= sat_ex;
        fwd_cnt_wb <= sat_wb;
      end
    end
  end

endmodule

// File: tb/tb_alu_operand_fwd_stage.sv
// Directed bench for alu_operand_fwd_stage (CNT_W=4 so that
// counter saturation is reachable in a few cycles).
module tb_alu_operand_fwd_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          stall, flush, in_valid;
  logic [AW-1:0] rs_addr, rt_addr;
  logic [DW-1:0] rs_data, rt_data, imm;
  logic          alu_src;
  logic          exmem_wr;
  logic [AW-1:0] exmem_rd;
  logic [DW-1:0] exmem_data;
  logic          memwb_wr;
  logic [AW-1:0] memwb_rd;
  logic [DW-1:0] memwb_data;
  logic [DW-1:0] op_a, op_b;
  logic          out_valid;
  logic [1:0]    sel_a, sel_b;
  logic [CW-1:0] fwd_cnt_ex, fwd_cnt_wb;

  int ntests = 0;
  int nfail  = 0;

  always #5 Clk = ~Clk;

  alu_operand_fwd_stage #(
    .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .stall(stall), .flush(flush),
    .in_valid(in_valid),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .imm(imm), .alu_src(alu_src),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd),
    .exmem_data(exmem_data),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid),
    .sel_a(sel_a), .sel_b(sel_b),
    .fwd_cnt_ex(fwd_cnt_ex),
    .fwd_cnt_wb(fwd_cnt_wb)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    stall = 0; flush = 0; in_valid = 0;
    rs_addr = '0; rt_addr = '0;
    rs_data = '0; rt_data = '0;
    imm = '0; alu_src = 0;
    exmem_wr = 0; exmem_rd = '0; exmem_data = '0;
    memwb_wr = 0; memwb_rd = '0; memwb_data = '0;
  endtask

  initial begin
    int exp_cnt;
    idle();
    Rst = 1;
    for (int i = 0; i < 2; i++) begin
      stall = 1'($urandom); flush = 1'($urandom);
      in_valid = 1; exmem_wr = 1; memwb_wr = 1;
      rs_addr = AW'($urandom); rt_addr = AW'($urandom);
      exmem_rd = rs_addr; memwb_rd = rt_addr;
      rs_data = $urandom; rt_data = $urandom;
      exmem_data = $urandom; memwb_data = $urandom;
      tick();
    end
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sel_a", 32'(sel_a), 0);
    chk("rst_sel_b", 32'(sel_b), 0);
    chk("rst_cnt_ex", 32'(fwd_cnt_ex), 0);
    chk("rst_cnt_wb", 32'(fwd_cnt_wb), 0);

    idle();
    Rst = 0;
    in_valid = 1; rs_addr = 3; rs_data = 32'h11;
    rt_addr = 4; rt_data = 32'h22;
    tick();
    chk("rf_op_a", op_a, 32'h11);
    chk("rf_sel_a", 32'(sel_a), 0);
    chk("rf_op_b", op_b, 32'h22);
    chk("rf_sel_b", 32'(sel_b), 0);
    chk("rf_valid", 32'(out_valid), 1);

    rs_addr = 5;
    exmem_wr = 1; exmem_rd = 5; exmem_data = 32'hAAAA;
    memwb_wr = 1; memwb_rd = 5; memwb_data = 32'hBBBB;
    tick();
    chk("ex_op_a", op_a, 32'hAAAA);
    chk("ex_sel_a", 32'(sel_a), 1);
    chk("ex_op_b", op_b, 32'h22);
    chk("ex_cnt_ex", 32'(fwd_cnt_ex), 1);
    chk("ex_cnt_wb", 32'(fwd_cnt_wb), 0);

    exmem_wr = 0;
    tick();
    chk("wb_op_a", op_a, 32'hBBBB);
    chk("wb_sel_a", 32'(sel_a), 2);
    chk("wb_cnt_ex", 32'(fwd_cnt_ex), 1);
    chk("wb_cnt_wb", 32'(fwd_cnt_wb), 1);

    rs_addr = 0; rs_data = 0;
    exmem_wr = 1; exmem_rd = 0; exmem_data = 32'h55;
    memwb_wr = 0;
    tick();
    chk("r0_op_a", op_a, 0);
    chk("r0_sel_a", 32'(sel_a), 0);
    chk("r0_cnt_ex", 32'(fwd_cnt_ex), 1);

    alu_src = 1; imm = 32'hFFFF_FFF0;
    rt_addr = 7; exmem_rd = 7; exmem_wr = 1;
    exmem_data = 32'h7777;
    tick();
    chk("imm_op_b", op_b, 32'hFFFF_FFF0);
    chk("imm_sel_b", 32'(sel_b), 3);
    chk("imm_cnt_ex", 32'(fwd_cnt_ex), 1);
    chk("imm_cnt_wb", 32'(fwd_cnt_wb), 1);

    alu_src = 0; exmem_wr = 0;
    rs_addr = 3; rs_data = 32'h1234;
    rt_addr = 4; rt_data = 32'h22;
    tick();
    chk("cap_op_a", op_a, 32'h1234);
    chk("cap_valid", 32'(out_valid), 1);

    stall = 1; flush = 1;
    exmem_wr = 1; exmem_rd = 3; exmem_data = 32'h9999;
    for (int i = 0; i < 3; i++) begin
      rs_data = 32'h5000 + 32'(i);
      tick();
      chk("stl_op_a", op_a, 32'h1234);
      chk("stl_valid", 32'(out_valid), 1);
      chk("stl_cnt_ex", 32'(fwd_cnt_ex), 1);
      chk("stl_cnt_wb", 32'(fwd_cnt_wb), 1);
    end

    stall = 0; flush = 1;
    tick();
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_cnt_ex", 32'(fwd_cnt_ex), 1);
    chk("fl_cnt_wb", 32'(fwd_cnt_wb), 1);

    flush = 0; in_valid = 0;
    tick();
    chk("iv0_valid", 32'(out_valid), 0);
    chk("iv0_cnt_ex", 32'(fwd_cnt_ex), 1);

    idle();
    Rst = 1;
    tick();
    chk("rst2_cnt_ex", 32'(fwd_cnt_ex), 0);
    chk("rst2_valid", 32'(out_valid), 0);
    Rst = 0;
    in_valid = 1;
    rs_addr = 9; rt_addr = 9;
    rs_data = 32'h1; rt_data = 32'h2;
    exmem_wr = 1; exmem_rd = 9;
    exmem_data = 32'hCAFE_0009;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_cnt = (2 * i > 15) ? 15 : 2 * i;
      chk("sat_cnt_ex", 32'(fwd_cnt_ex), 32'(exp_cnt));
      chk("sat_op_a", op_a, 32'hCAFE_0009);
      chk("sat_op_b", op_b, 32'hCAFE_0009);
      chk("sat_sel_b", 32'(sel_b), 1);
    end
    chk("sat_cnt_wb", 32'(fwd_cnt_wb), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/alu_operand_fwd_stage.md
Name: alu_operand_fwd_stage

Overview:
- Registered operand-select stage between ID/EX and the ALU in the pipelined SAD datapath.
- Resolves forwarding internally for both ALU operands from:
  - register-file data,
  - EX/MEM result,
  - MEM/WB result,
  - an immediate (operand B only).
- Replaces the free-standing combinational operand muxes.
- Adds a 1-cycle pipeline register, stall/flush control and saturating forwarding-event counters for performance debug.

Parameters:
- DATA_W, 32, operand/result width.
- ADDR_W, 5, register address width.
- CNT_W, 16, width of each forwarding-event counter.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all registered outputs and counters.
- flush  in  1  kill the instruction being captured this cycle.
- in_valid  in  1  ID/EX holds a valid instruction.
- rs_addr  in  ADDR_W  source A register number.
- rt_addr  in  ADDR_W  source B register number.
- rs_data  in  DATA_W  register-file value for A.
- rt_data  in  DATA_W  register-file value for B.
- imm  in  DATA_W  sign-extended immediate.
- alu_src  in  1  1 = operand B is imm.
- exmem_wr  in  1  EX/MEM writes a register.
- exmem_rd  in  ADDR_W  EX/MEM destination.
- exmem_data  in  DATA_W  EX/MEM result.
- memwb_wr  in  1  MEM/WB writes a register.
- memwb_rd  in  ADDR_W  MEM/WB destination.
- memwb_data  in  DATA_W  MEM/WB writeback value.
- op_a  out  DATA_W  registered ALU operand A.
- op_b  out  DATA_W  registered ALU operand B.
- out_valid  out  1  op_a/op_b are valid.
- sel_a  out  2  registered source of A: 0 regfile, 1 EX/MEM, 2 MEM/WB.
- sel_b  out  2  registered source of B: 0 regfile, 1 EX/MEM, 2 MEM/WB, 3 imm.
- fwd_cnt_ex  out  CNT_W  count of operands taken from EX/MEM.
- fwd_cnt_wb  out  CNT_W  count of operands taken from MEM/WB.

Behaviour:
- Reset (Rst=1 at an edge): op_a=0, op_b=0, out_valid=0, sel_a=0, sel_b=0, fwd_cnt_ex=0, fwd_cnt_wb=0.
  - Rst has priority over stall and flush.
  - Reset mid-operation discards any in-flight operand.
- Source select, per operand with address r (rs_addr for A, rt_addr for B). Priority is highest first:
  - exmem_wr && exmem_rd==r && r!=0 -> EX/MEM.
  - else memwb_wr && memwb_rd==r && r!=0 -> MEM/WB.
  - else -> regfile.
  - Register 0 is never forwarded; it always uses regfile data.
- Operand B immediate: if alu_src=1, B = imm and sel_b=3. This overrides all forwarding for B, and no counter increment is contributed by B.
- Latency: exactly 1 cycle. Values selected from inputs at edge N appear on outputs after edge N.
- stall=1 (and Rst=0):
  - all outputs and counters hold;
  - inputs are ignored;
  - flush is also ignored while stalled.
- flush=1, stall=0: out_valid<=0, counters unchanged; op_a/op_b/sel values may update but are don't-care.
- in_valid=0, stall=0, flush=0: out_valid<=0, counters unchanged.
- Normal capture (in_valid=1, stall=0, flush=0):
  - out_valid<=1; op_a, op_b, sel_a, sel_b load the selected values.
  - fwd_cnt_ex increments by the number of operands (0, 1 or 2) sourced from EX/MEM.
  - fwd_cnt_wb increments likewise for MEM/WB.
- Counters saturate at 2^CNT_W-1; no wrap. An increment of 2 when at max-1 yields max.
- A and B resolve independently; the same register on both operands forwards to both.
- Data is passed bit-exact; no arithmetic on operands.

Test Plan:
- Reset: Rst=1 for 2 cycles with random inputs -> all outputs 0. Release Rst, apply in_valid=1, rs_addr=3, rs_data=0x11 -> next cycle op_a=0x11, sel_a=0, out_valid=1.
- EX/MEM priority over MEM/WB:
  - Stimulus: rs_addr=5, exmem_wr=1, exmem_rd=5, exmem_data=0xAAAA; memwb_wr=1, memwb_rd=5, memwb_data=0xBBBB.
  - Response: op_a=0xAAAA, sel_a=1, fwd_cnt_ex=1.
  - Then with exmem_wr=0 -> op_a=0xBBBB, sel_a=2, fwd_cnt_wb=1.
- Zero register and immediate override:
  - Stimulus: rs_addr=0, exmem_wr=1, exmem_rd=0, rs_data=0 -> op_a=0, sel_a=0.
  - Stimulus: alu_src=1, imm=0xFFFFFFF0, rt_addr=exmem_rd=7, exmem_wr=1 -> op_b=0xFFFFFFF0, sel_b=3, fwd_cnt_ex unchanged by B.
- Stall/flush:
  - Capture op_a=0x1234.
  - Assert stall 3 cycles while changing rs_data and raising flush -> op_a=0x1234, out_valid=1, counters frozen.
  - Drop stall with flush=1 -> out_valid=0, counters unchanged.
- Dual forward and saturation:
  - Stimulus: CNT_W=4, rs_addr=rt_addr=exmem_rd=9, exmem_wr=1, in_valid=1.
  - Response: fwd_cnt_ex goes 0,2,4,…,14, then holds at 15 on subsequent cycles.
  - Both op_a and op_b equal exmem_data throughout.
